// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the execute-stage ALU/MDU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_mdu_seq_muldiv.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with the sign fixup folded into the final step.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic                busy_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     dvs_r;
  logic [4:0]          op_r;
  logic                neg_res_r;
  logic                neg_rem_r;

  logic                a_neg_s, b_neg_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s;
  logic [XLEN:0]       rem_sh_s;
  logic                ge_s;
  logic [XLEN-1:0]     diff_s;
  logic [XLEN:0]       sum_s;
  logic [2*XLEN-1:0]   next_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     q_s, r_s;

  // operand magnitudes and one iteration step (multiply or divide)
  always_comb begin
    a_neg_s  = is_signed_a(op) & a[XLEN-1];
    b_neg_s  = is_signed_b(op) & b[XLEN-1];
    a_mag_s  = a_neg_s ? ((~a) + ONE_X) : a;
    b_mag_s  = b_neg_s ? ((~b) + ONE_X) : b;
    rem_sh_s = acc_r[2*XLEN-1:XLEN-1];
    ge_s     = (rem_sh_s >= {1'b0, dvs_r});
    diff_s   = rem_sh_s[XLEN-1:0] - dvs_r;
    sum_s    = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, (acc_r[0] ? dvs_r : {XLEN{1'b0}})};
    if (is_div(op_r)) begin
      next_s = {(ge_s ? diff_s : rem_sh_s[XLEN-1:0]), acc_r[XLEN-2:0], ge_s};
    end else begin
      next_s = {sum_s, acc_r[XLEN-1:1]};
    end
  end

  // sign fixup applied to the post-step value so the last step yields the final result
  always_comb begin
    prod_s = neg_res_r ? ((~next_s) + ONE_2X) : next_s;
    q_s    = neg_res_r ? ((~next_s[XLEN-1:0]) + ONE_X) : next_s[XLEN-1:0];
    r_s    = neg_rem_r ? ((~next_s[2*XLEN-1:XLEN]) + ONE_X) : next_s[2*XLEN-1:XLEN];
    case (op_r)
      OP_MUL:                       result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = q_s;
      OP_REM, OP_REMU:              result = r_s;
      default:                      result = {XLEN{1'b0}};
    endcase
  end

  assign done = busy_r && (cnt_r == CNT_W'(XLEN-1));

  // iteration counter and accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      dvs_r     <= {XLEN{1'b0}};
      op_r      <= 5'd0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (flush) begin
      busy_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      acc_r  <= {(2*XLEN){1'b0}};
    end else if (start) begin
      busy_r    <= 1'b1;
      cnt_r     <= {CNT_W{1'b0}};
      acc_r     <= {{XLEN{1'b0}}, a_mag_s};
      dvs_r     <= b_mag_s;
      op_r      <= op;
      neg_res_r <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
    end else if (busy_r) begin
      acc_r <= next_s;
      if (done) begin
        busy_r <= 1'b0;
        cnt_r  <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU with iterative M-extension multiply/divide behind valid/ready handshakes.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] BUSY = ST_BUSY;
  localparam logic [1:0] DONE = ST_DONE;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]         state_r;
  logic [XLEN-1:0]    y_r;
  logic               zero_r;
  logic [XLEN-1:0]    res_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic               div0_s, ovf_s, special_s;
  logic               accept_s, start_s;
  logic               md_done_s;
  logic [XLEN-1:0]    md_result_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign y         = y_r;
  assign zero      = zero_r;
  assign shamt_s   = b[SHAMT_W-1:0];
  assign accept_s  = in_valid && in_ready && !flush;
  assign start_s   = accept_s && is_muldiv(op) && !special_s;

  // single-cycle results, including the divide corner cases that bypass iteration
  always_comb begin
    div0_s    = (b == {XLEN{1'b0}});
    ovf_s     = (a == MIN_NEG) && (b == ALL_ONES);
    special_s = (div0_s && is_div(op)) || (ovf_s && ((op == OP_DIV) || (op == OP_REM)));
    case (op)
      OP_ADD:  res_s = a + b;
      OP_SUB:  res_s = a - b;
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_XOR:  res_s = a ^ b;
      OP_SLT:  res_s = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_s = {{(XLEN-1){1'b0}}, (a < b)};
      OP_SLL:  res_s = a << shamt_s;
      OP_SRL:  res_s = a >> shamt_s;
      OP_SRA:  res_s = $unsigned($signed(a) >>> shamt_s);
      OP_DIV:  res_s = div0_s ? ALL_ONES : (ovf_s ? a : {XLEN{1'b0}});
      OP_DIVU: res_s = div0_s ? ALL_ONES : {XLEN{1'b0}};
      OP_REM:  res_s = div0_s ? a : {XLEN{1'b0}};
      OP_REMU: res_s = div0_s ? a : {XLEN{1'b0}};
      default: res_s = {XLEN{1'b0}};
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .start   (start_s),
    .op      (op),
    .a       (a),
    .b       (b),
    .done    (md_done_s),
    .result  (md_result_s)
  );

  // FSM, result capture and hold until the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      y_r     <= {XLEN{1'b0}};
      zero_r  <= 1'b0;
    end else if (flush) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && start_s) begin
            state_r <= BUSY;
          end else if (accept_s) begin
            state_r <= DONE;
            y_r     <= res_s;
            zero_r  <= (res_s == {XLEN{1'b0}});
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (md_done_s) begin
            state_r <= DONE;
            y_r     <= md_result_s;
            zero_r  <= (md_result_s == {XLEN{1'b0}});
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq at XLEN=32: reference model results are queued at drive time.
module tb_alu_mdu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = 5'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic        zero;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] y;
    logic        zero;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } stim_t;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .zero(zero)
  );

  function automatic logic [31:0] model_y(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z);
    longint sx, sz;
    longint unsigned ux, uz;
    logic [63:0] p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sz = longint'($signed(z));
    ux = {32'd0, x};
    uz = {32'd0, z};
    p = 64'd0;
    r = 32'd0;
    case (o)
      OP_ADD:    r = x + z;
      OP_SUB:    r = x - z;
      OP_AND:    r = x & z;
      OP_OR:     r = x | z;
      OP_XOR:    r = x ^ z;
      OP_SLT:    r = ($signed(x) < $signed(z)) ? 32'd1 : 32'd0;
      OP_SLTU:   r = (x < z) ? 32'd1 : 32'd0;
      OP_SLL:    r = x << z[4:0];
      OP_SRL:    r = x >> z[4:0];
      OP_SRA:    r = $signed(x) >>> z[4:0];
      OP_MUL:    begin p = ux * uz; r = p[31:0]; end
      OP_MULH:   begin p = sx * sz; r = p[63:32]; end
      OP_MULHSU: begin p = sx * longint'(uz); r = p[63:32]; end
      OP_MULHU:  begin p = ux * uz; r = p[63:32]; end
      OP_DIV: begin
        if (z == 32'd0) r = 32'hFFFFFFFF;
        else if (x == 32'h80000000 && z == 32'hFFFFFFFF) r = x;
        else begin p = sx / sz; r = p[31:0]; end
      end
      OP_DIVU: r = (z == 32'd0) ? 32'hFFFFFFFF : x / z;
      OP_REM: begin
        if (z == 32'd0) r = x;
        else if (x == 32'h80000000 && z == 32'hFFFFFFFF) r = 32'd0;
        else begin p = sx % sz; r = p[31:0]; end
      end
      OP_REMU: r = (z == 32'd0) ? x : x % z;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z);
    logic iter;
    iter = (o >= 5'd10) && (o <= 5'd17);
    if (o >= 5'd14 && o <= 5'd17 && z == 32'd0) iter = 1'b0;
    if ((o == 5'd14 || o == 5'd16) && x == 32'h80000000 && z == 32'hFFFFFFFF) iter = 1'b0;
    return iter ? 33 : 1;
  endfunction

  // drive one op, queue its expectation, and observe the result and its latency
  task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z,
                        output logic [31:0] yo, output logic zo, output int lat);
    exp_t e;
    int w;
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    e.y = model_y(o, x, z);
    e.zero = (e.y == 32'd0);
    e.lat = model_lat(o, x, z);
    sb.push_back(e);
    op = o; a = x; b = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    yo = y;
    zo = zero;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 32'd0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b y=%h zero=%b, required 1 0 00000000 0", in_ready, out_valid, y, zero);
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_simple();
    stim_t t[7] = '{
      '{OP_ADD,  32'hFFFFFFFF, 32'h00000001}, '{OP_SLT,  32'hFFFFFFFF, 32'h00000001},
      '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001}, '{OP_SRA,  32'h80000000, 32'h00000004},
      '{OP_SUB,  32'h00000005, 32'h00000009}, '{OP_SLL,  32'h00000003, 32'h0000011F},
      '{OP_SRL,  32'h80000000, 32'h00000004}};
    logic [31:0] yo; logic zo; int lat; exp_t e;
    for (int i = 0; i < 7 + 12; i++) begin
      if (i < 7) run_op(t[i].op, t[i].a, t[i].b, yo, zo, lat);
      else run_op(5'($urandom_range(0, 9)), $urandom, $urandom, yo, zo, lat);
      e = sb.pop_front();
      checks++;
      if (yo !== e.y || zo !== e.zero || lat != e.lat) begin
        failures++;
        $display("FAIL simple[%0d] op=%0d: y=%h zero=%b lat=%0d, required y=%h zero=%b lat=%0d", i, op, yo, zo, lat, e.y, e.zero, e.lat);
      end
    end
  endtask

  task automatic test_muldiv();
    stim_t t[8] = '{
      '{OP_MULH,  32'h80000000, 32'h80000000}, '{OP_MUL,    32'h00000007, 32'hFFFFFFFD},
      '{OP_REM,   32'hFFFFFFF9, 32'h00000002}, '{OP_DIV,    32'hFFFFFFF9, 32'h00000002},
      '{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF}, '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF},
      '{OP_REMU,  32'hFFFFFFFF, 32'h00000010}, '{OP_DIVU,   32'h00000064, 32'h00000007}};
    logic [31:0] yo; logic zo; int lat; exp_t e;
    for (int i = 0; i < 8 + 16; i++) begin
      if (i < 8) run_op(t[i].op, t[i].a, t[i].b, yo, zo, lat);
      else run_op(5'($urandom_range(10, 17)), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom, yo, zo, lat);
      e = sb.pop_front();
      checks++;
      if (yo !== e.y || zo !== e.zero || lat != e.lat) begin
        failures++;
        $display("FAIL muldiv[%0d] op=%0d: y=%h zero=%b lat=%0d, required y=%h zero=%b lat=%0d", i, op, yo, zo, lat, e.y, e.zero, e.lat);
      end
    end
  endtask

  task automatic test_special();
    stim_t t[6] = '{
      '{OP_DIV,  32'h80000000, 32'hFFFFFFFF}, '{OP_REM,  32'h80000000, 32'hFFFFFFFF},
      '{OP_DIVU, 32'h00000005, 32'h00000000}, '{OP_REMU, 32'h00000005, 32'h00000000},
      '{OP_DIV,  32'hFFFFFFF0, 32'h00000000}, '{5'd25,   32'h12345678, 32'h9ABCDEF0}};
    logic [31:0] yo; logic zo; int lat; exp_t e;
    for (int i = 0; i < 6; i++) begin
      run_op(t[i].op, t[i].a, t[i].b, yo, zo, lat);
      e = sb.pop_front();
      checks++;
      if (yo !== e.y || zo !== e.zero || lat != e.lat) begin
        failures++;
        $display("FAIL special[%0d] op=%0d: y=%h zero=%b lat=%0d, required y=%h zero=%b lat=%0d", i, op, yo, zo, lat, e.y, e.zero, e.lat);
      end
    end
  endtask

  task automatic test_flush();
    int seen;
    @(posedge clk); #1;
    op = OP_DIV; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_busy: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_drop: out_valid high %0d cycles, required 0", seen);
    end
    op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_accept: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_done: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_stall();
    logic [31:0] yo; logic zo; int lat; exp_t e; int bad;
    out_ready = 1'b0;
    run_op(OP_DIVU, 32'd100, 32'd7, yo, zo, lat);
    e = sb.pop_front();
    checks++;
    if (yo !== e.y || lat != e.lat) begin
      failures++;
      $display("FAIL stall_result: y=%h lat=%0d, required y=%h lat=%0d", yo, lat, e.y, e.lat);
    end
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (y !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold: %0d bad cycles (last y=%h out_valid=%b in_ready=%b), required 0", bad, y, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int w;
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    e.y = model_y(OP_ADD, 32'd3, 32'd4); e.zero = 1'b0; e.lat = 1; sb.push_back(e);
    op = OP_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    e.y = model_y(OP_SUB, 32'd10, 32'd4); e.zero = 1'b0; e.lat = 1; sb.push_back(e);
    op = OP_SUB; a = 32'd10; b = 32'd4;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e.y || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: out_valid=%b y=%h in_ready=%b, required 1 %h 0", out_valid, y, in_ready, e.y);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_bubble: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || y !== e.y) begin
      failures++;
      $display("FAIL b2b_second: out_valid=%b y=%h, required 1 %h", out_valid, y, e.y);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] yo; logic zo; int lat; exp_t e; int w;
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    op = OP_MUL; a = 32'd7; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 32'd0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b y=%h zero=%b, required 0 1 00000000 0", out_valid, in_ready, y, zero);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    run_op(OP_MUL, 32'd123, 32'd456, yo, zo, lat);
    e = sb.pop_front();
    checks++;
    if (yo !== e.y || lat != e.lat) begin
      failures++;
      $display("FAIL after_reset_mul: y=%h lat=%0d, required y=%h lat=%0d", yo, lat, e.y, e.lat);
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_muldiv();
    test_special();
    test_flush();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
